// File: rtl/board_printer.sv
// board_printer: renders two player bitboards ('O' = board A, 'X' = board B)
// as ASCII text over the shared UART TX byte interface, row by row, CR LF
// after each row. One byte per UART handshake, each strobe followed by a
// one-cycle gap so the UART has time to drop its ready flag.
// Optional feature: define BOARD_PRINTER_ROWNUM_EN to prefix every row with
// its row digit and a ':' character.
module board_printer #(
  parameter int ROWS = 3,
  parameter int COLS = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 req_i,
  input  logic [ROWS*COLS-1:0] board_a_i,
  input  logic [ROWS*COLS-1:0] board_b_i,
  output logic                 ready_o,
  output logic                 done_o,
  output logic                 uart_wr_o,
  output logic [7:0]           uart_d_o,
  input  logic                 uart_ready_i
);

  localparam int N = ROWS * COLS;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_CELL  = 4'd1;
  localparam logic [3:0] S_CR    = 4'd2;
  localparam logic [3:0] S_LF    = 4'd3;
  localparam logic [3:0] S_GAP   = 4'd4;
  localparam logic [3:0] S_DONE  = 4'd5;
`ifdef BOARD_PRINTER_ROWNUM_EN
  localparam logic [3:0] S_PRE   = 4'd6;
  localparam logic [3:0] S_COLON = 4'd7;
  localparam logic [3:0] S_ROW   = S_PRE;
`else
  localparam logic [3:0] S_ROW   = S_CELL;
`endif

  localparam logic [7:0] COLS8    = 8'(COLS);
  localparam logic [3:0] LAST_COL = 4'(COLS - 1);
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  logic [3:0]   state_q, state_d;
  logic [3:0]   after_q, after_d;
  logic [3:0]   row_q, row_d;
  logic [3:0]   col_q, col_d;
  logic [N-1:0] boardA_q, boardA_d;
  logic [N-1:0] boardB_q, boardB_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         uartWr_q, uartWr_d;
  logic [7:0]   uartD_q, uartD_d;

  logic [7:0]   cellIdx;
  logic [N-1:0] shiftA, shiftB;
  logic [7:0]   cellChar;

  // Decode the character for the current cell from the latched boards
  always_comb begin
    cellIdx = ({4'd0, row_q} * COLS8) + {4'd0, col_q};
    shiftA  = boardA_q >> cellIdx;
    shiftB  = boardB_q >> cellIdx;
    case ({shiftA[0], shiftB[0]})
      2'b10:   cellChar = 8'h4F;
      2'b01:   cellChar = 8'h58;
      2'b11:   cellChar = 8'h23;
      default: cellChar = 8'h2E;
    endcase
  end

  // Sequencer: each emitting state strobes one byte when the UART is ready,
  // then parks in GAP with the follow-on state remembered in after_q
  always_comb begin
    state_d  = state_q;
    after_d  = after_q;
    row_d    = row_q;
    col_d    = col_q;
    boardA_d = boardA_q;
    boardB_d = boardB_q;
    busy_d   = busy_q;
    uartWr_d = 1'b0;
    uartD_d  = uartD_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          boardA_d = board_a_i;
          boardB_d = board_b_i;
          row_d    = 4'd0;
          col_d    = 4'd0;
          busy_d   = 1'b1;
          state_d  = S_ROW;
        end else begin
          busy_d = 1'b0;
        end
      end
`ifdef BOARD_PRINTER_ROWNUM_EN
      S_PRE: begin
        if (uart_ready_i) begin
          uartWr_d = 1'b1;
          uartD_d  = 8'h30 + {4'd0, row_q};
          after_d  = S_COLON;
          state_d  = S_GAP;
        end
      end
      S_COLON: begin
        if (uart_ready_i) begin
          uartWr_d = 1'b1;
          uartD_d  = 8'h3A;
          after_d  = S_CELL;
          state_d  = S_GAP;
        end
      end
`endif
      S_CELL: begin
        if (uart_ready_i) begin
          uartWr_d = 1'b1;
          uartD_d  = cellChar;
          state_d  = S_GAP;
          if (col_q == LAST_COL) begin
            col_d   = 4'd0;
            after_d = S_CR;
          end else begin
            col_d   = col_q + 4'd1;
            after_d = S_CELL;
          end
        end
      end
      S_CR: begin
        if (uart_ready_i) begin
          uartWr_d = 1'b1;
          uartD_d  = 8'h0D;
          after_d  = S_LF;
          state_d  = S_GAP;
        end
      end
      S_LF: begin
        if (uart_ready_i) begin
          uartWr_d = 1'b1;
          uartD_d  = 8'h0A;
          state_d  = S_GAP;
          if (row_q == LAST_ROW) begin
            after_d = S_DONE;
          end else begin
            row_d   = row_q + 4'd1;
            after_d = S_ROW;
          end
        end
      end
      S_GAP: begin
        state_d = after_q;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset aborts any print in progress
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      after_q  <= S_IDLE;
      row_q    <= 4'd0;
      col_q    <= 4'd0;
      boardA_q <= '0;
      boardB_q <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      uartWr_q <= 1'b0;
      uartD_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      after_q  <= after_d;
      row_q    <= row_d;
      col_q    <= col_d;
      boardA_q <= boardA_d;
      boardB_q <= boardB_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      uartWr_q <= uartWr_d;
      uartD_q  <= uartD_d;
    end
  end

  assign ready_o   = ~req_i & ~busy_q & (state_q == S_IDLE);
  assign done_o    = done_q;
  assign uart_wr_o = uartWr_q;
  assign uart_d_o  = uartD_q;

endmodule

// File: tb/tb_board_printer.sv
// tb_board_printer: directed bench for board_printer (3x3). Bytes written to
// the UART are captured by a monitor; each print is compared against a hand
// written expected text. Builds with or without BOARD_PRINTER_ROWNUM_EN.
module tb_board_printer;

  typedef logic [7:0] bq_t[$];

  logic       clk;
  logic       resetN;
  logic       req;
  logic [8:0] boardA;
  logic [8:0] boardB;
  logic       ready;
  logic       done;
  logic       uartWr;
  logic [7:0] uartD;
  logic       uartReady;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] got[$];
  int  doneCount  = 0;
  int  consecCount = 0;
  logic prevWr    = 1'b0;

  board_printer #(.ROWS(3), .COLS(3)) dut (
    .clk_i       (clk),
    .reset_n_i   (resetN),
    .req_i       (req),
    .board_a_i   (boardA),
    .board_b_i   (boardB),
    .ready_o     (ready),
    .done_o      (done),
    .uart_wr_o   (uartWr),
    .uart_d_o    (uartD),
    .uart_ready_i(uartReady)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor on the falling edge: capture every strobed byte, flag back-to-back strobes
  always @(negedge clk) begin
    if (resetN) begin
      if (uartWr) begin
        got.push_back(uartD);
        if (prevWr) consecCount++;
      end
      if (done) doneCount++;
      prevWr = uartWr;
    end else begin
      prevWr = 1'b0;
    end
  end

  // Single comparison point: every check in the bench goes through here
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Assemble the expected byte stream of a 3-row print from its row texts
  function automatic bq_t buildText(input string r0, input string r1, input string r2);
    bq_t q;
    string rows[3];
    rows[0] = r0;
    rows[1] = r1;
    rows[2] = r2;
    for (int r = 0; r < 3; r++) begin
`ifdef BOARD_PRINTER_ROWNUM_EN
      q.push_back(8'h30 + 8'(r));
      q.push_back(8'h3A);
`endif
      for (int i = 0; i < rows[r].len(); i++) q.push_back(8'(rows[r][i]));
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
    return q;
  endfunction

  // Pulse req for one cycle with the given boards; ready must be low while req is high
  task automatic applyStimulus(input logic [8:0] a, input logic [8:0] b, input string tag);
    @(negedge clk);
    boardA = a;
    boardB = b;
    req    = 1'b1;
    #1;
    checkOutput({tag, "_ready_with_req"}, 32'(ready), 32'd0);
    @(negedge clk);
    req    = 1'b0;
    boardA = ~a;
    boardB = ~b;
  endtask

  // Run one full print and compare the captured text
  task automatic runPrint(input logic [8:0] a, input logic [8:0] b, input bq_t expText,
                          input int stallAt, input bit spamReq, input string tag);
    int  startIdx;
    int  startDone;
    int  startConsec;
    int  n;
    bit  finished;
    logic [7:0] held;
    startIdx    = got.size();
    startDone   = doneCount;
    startConsec = consecCount;
    finished    = 1'b0;
    applyStimulus(a, b, tag);
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      #1;
      n = got.size() - startIdx;
      req = spamReq && (n < expText.size() - 2) && ((cyc % 5) == 2);
      if (stallAt >= 0 && n == stallAt) begin
        uartReady = 1'b0;
        held = uartD;
        for (int s = 0; s < 20; s++) begin
          @(negedge clk);
          #1;
          checkOutput({tag, "_stall_wr"}, 32'(uartWr), 32'd0);
          checkOutput({tag, "_stall_d"}, 32'(uartD), 32'(held));
        end
        uartReady = 1'b1;
        stallAt = -1;
      end
      if (doneCount != startDone) finished = 1'b1;
    end
    req = 1'b0;
    checkOutput({tag, "_done_seen"}, 32'(finished), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput({tag, "_byte_count"}, 32'(got.size() - startIdx), 32'(expText.size()));
    for (int i = 0; i < expText.size(); i++) begin
      if (startIdx + i < got.size())
        checkOutput($sformatf("%s_byte%0d", tag, i), 32'(got[startIdx + i]), 32'(expText[i]));
    end
    checkOutput({tag, "_no_consecutive_wr"}, 32'(consecCount - startConsec), 32'd0);
    checkOutput({tag, "_done_once"}, 32'(doneCount - startDone), 32'd1);
    checkOutput({tag, "_ready_after"}, 32'(ready), 32'd1);
  endtask

  initial begin
    bq_t empty;
    int  startIdx;
    bit  reached;
    resetN    = 1'b0;
    req       = 1'b0;
    boardA    = 9'd0;
    boardB    = 9'd0;
    uartReady = 1'b1;
    empty     = buildText("...", "...", "...");

    $display("[TB] reset state");
    @(negedge clk);
    #1;
    checkOutput("reset_uart_wr", 32'(uartWr), 32'd0);
    checkOutput("reset_uart_d", 32'(uartD), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_ready", 32'(ready), 32'd0);
    #1 resetN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_release", 32'(ready), 32'd1);

    $display("[TB] test 1: empty boards");
    runPrint(9'd0, 9'd0, empty, -1, 1'b0, "t1_empty");

    $display("[TB] test 2: mixed boards");
    runPrint(9'b000010001, 9'b100000010, buildText("OX.", ".O.", "..X"), -1, 1'b0, "t2_mixed");

    $display("[TB] test 3: uart stall mid-row");
    runPrint(9'b000010001, 9'b100000010, buildText("OX.", ".O.", "..X"), 6, 1'b0, "t3_stall");

    $display("[TB] test 4: corrupt cell and repeated req");
    runPrint(9'b000010000, 9'b000010000, buildText("...", ".#.", "..."), -1, 1'b1, "t4_corrupt");

    $display("[TB] test 5: reset mid-print");
    startIdx = got.size();
    reached  = 1'b0;
    applyStimulus(9'd0, 9'd0, "t5_abort");
    for (int cyc = 0; cyc < 500 && !reached; cyc++) begin
      @(negedge clk);
      #1;
      if (got.size() - startIdx >= 7) reached = 1'b1;
    end
    checkOutput("t5_reached_7_bytes", 32'(reached), 32'd1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("t5_reset_wr", 32'(uartWr), 32'd0);
    checkOutput("t5_reset_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("t5_ready_in_reset", 32'(ready), 32'd0);
    checkOutput("t5_bytes_at_abort", 32'(got.size() - startIdx), 32'd7);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_ready_after_release", 32'(ready), 32'd1);
    runPrint(9'd0, 9'd0, empty, -1, 1'b0, "t5_reprint");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
